pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RISC-V core; supersedes per-stage ad-hoc hazard gating.

---
 rtl/pipeline_stall_controller.sv | 174 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage core: load-use, data-memory wait
// and taken-branch flush handling in one FSM, plus stall/flush perf counters.
// Control outputs are Mealy: they react to the current inputs in the same cycle.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_ex,
  input  logic [4:0]       rd_addr_ex,
  input  logic [4:0]       rs1_addr_id,
  input  logic [4:0]       rs2_addr_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic             branch_taken_mem,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             timeout_err
);

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            load_use;
  logic            flush_inc;
  logic            timeout_set;

  assign state = state_q;

  // Load-use hazard between the EX load and the ID consumer; x0 never stalls.
  assign load_use = mem_read_ex && (rd_addr_ex != 5'd0) &&
                    ((rs1_used_id && (rd_addr_ex == rs1_addr_id)) ||
                     (rs2_used_id && (rd_addr_ex == rs2_addr_id)));

  // Next-state and Mealy control outputs; branch > memory wait > load-use in RUN.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    mem_wb_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    flush_inc     = 1'b0;
    timeout_set   = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
      flush_cnt_d  = '0;
      wait_cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken_mem) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
            flush_cnt_d  = FC_W'(FLUSH_CYCLES - 1);
            if (FLUSH_CYCLES > 1) state_d = ST_FLUSH;
          end else if (dmem_req_mem && !dmem_ready) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            wait_cnt_d    = WC_W'(1);
            state_d       = ST_MEM_WAIT;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            wait_cnt_d = '0;
            state_d    = ST_RUN;
          end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
            timeout_set = 1'b1;
            wait_cnt_d  = '0;
            state_d     = ST_RUN;
          end else begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            wait_cnt_d    = wait_cnt_q + WC_W'(1);
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          if (branch_taken_mem) begin
            flush_inc   = 1'b1;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
          end else if (flush_cnt_q <= FC_W'(1)) begin
            flush_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Saturating perf counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
      if (timeout_set)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a cycle-level reference model.
module tb_pipeline_stall_controller;

  localparam int FLUSH_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 15;
  localparam int CNT_W        = 16;

  logic             clk;
  logic             rst;
  logic             mem_read_ex;
  logic [4:0]       rd_addr_ex, rs1_addr_id, rs2_addr_id;
  logic             rs1_used_id, rs2_used_id;
  logic             branch_taken_mem, dmem_req_mem, dmem_ready;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic             id_ex_bubble, mem_wb_bubble;
  logic             if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             timeout_err;

  pipeline_stall_controller #(
    .FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_read_ex(mem_read_ex), .rd_addr_ex(rd_addr_ex),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .branch_taken_mem(branch_taken_mem), .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .state(state), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frozen cycles so far in a memory wait, FLUSH cycles still to come.
  bit m_valid = 1'b0;
  int m_frozen = 0;
  int m_flush_left = 0;
  int m_stalls = 0;
  int m_flushes = 0;
  bit m_terr = 1'b0;

  // Output bit order: pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, id_ex_bub, mem_wb_bub, if_id_fl, id_ex_fl, ex_mem_fl
  localparam logic [9:0] O_IDLE   = 10'b11111_00_000;
  localparam logic [9:0] O_RESET  = 10'b01111_00_111;
  localparam logic [9:0] O_FREEZE = 10'b00000_01_000;
  localparam logic [9:0] O_LU     = 10'b00111_10_000;
  localparam logic [9:0] O_BR     = 10'b11111_00_111;
  localparam logic [9:0] O_FLUSH  = 10'b11111_00_100;

  function automatic bit lu_hazard();
    return mem_read_ex && rd_addr_ex != 5'd0 &&
           ((rs1_used_id && rd_addr_ex == rs1_addr_id) ||
            (rs2_used_id && rd_addr_ex == rs2_addr_id));
  endfunction

  function automatic logic [9:0] model_outs();
    if (rst) return O_RESET;
    if (m_frozen > 0)
      return (dmem_ready || m_frozen == MEM_TIMEOUT - 1) ? O_IDLE : O_FREEZE;
    if (m_flush_left > 0) return O_FLUSH;
    if (branch_taken_mem) return O_BR;
    if (dmem_req_mem && !dmem_ready) return O_FREEZE;
    if (lu_hazard()) return O_LU;
    return O_IDLE;
  endfunction

  function automatic int model_state();
    if (m_frozen > 0) return 1;
    if (m_flush_left > 0) return 2;
    return 0;
  endfunction

  // Advance the model on every rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    logic [9:0] o;
    o = model_outs();
    if (rst) begin
      m_valid = 1'b1;
      m_frozen = 0; m_flush_left = 0; m_stalls = 0; m_flushes = 0; m_terr = 1'b0;
    end else begin
      if (!o[9] && m_stalls < 65535) m_stalls++;
      if (m_frozen > 0) begin
        if (dmem_ready) m_frozen = 0;
        else if (m_frozen == MEM_TIMEOUT - 1) begin m_frozen = 0; m_terr = 1'b1; end
        else m_frozen++;
      end else if (m_flush_left > 0) begin
        if (branch_taken_mem) begin m_flush_left = FLUSH_CYCLES - 1; m_flushes++; end
        else m_flush_left--;
      end else if (branch_taken_mem) begin
        m_flush_left = FLUSH_CYCLES - 1; m_flushes++;
      end else if (dmem_req_mem && !dmem_ready) begin
        m_frozen = 1;
      end
    end
  end

  // Compare every cycle once the model is anchored by a reset.
  always @(negedge clk) begin
    logic [9:0] exp_o, act_o;
    if (m_valid) begin
      exp_o = model_outs();
      act_o = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush, ex_mem_flush};
      vectors++;
      if (act_o !== exp_o) begin
        miscompares++;
        $display("FAIL ctrl_outs t=%0t got=%b want=%b", $time, act_o, exp_o);
      end
      vectors++;
      if (state !== 2'(model_state())) begin
        miscompares++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, state, model_state());
      end
      vectors++;
      if (stall_cycles !== 16'(m_stalls)) begin
        miscompares++;
        $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, m_stalls);
      end
      vectors++;
      if (flush_count !== 16'(m_flushes)) begin
        miscompares++;
        $display("FAIL flush_count t=%0t got=%0d want=%0d", $time, flush_count, m_flushes);
      end
      vectors++;
      if (timeout_err !== m_terr) begin
        miscompares++;
        $display("FAIL timeout_err t=%0t got=%0d want=%0d", $time, timeout_err, m_terr);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit mre, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2, input bit br,
                       input bit req, input bit rdy);
    rst = r; mem_read_ex = mre; rd_addr_ex = rd; rs1_addr_id = rs1; rs2_addr_id = rs2;
    rs1_used_id = u1; rs2_used_id = u2; branch_taken_mem = br; dmem_req_mem = req; dmem_ready = rdy;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_read_ex = 1'b0; rd_addr_ex = '0; rs1_addr_id = '0; rs2_addr_id = '0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; branch_taken_mem = 1'b0;
    dmem_req_mem = 1'b0; dmem_ready = 1'b1;
    tick();

    // Reset: pc held, all flushes asserted, counters cleared.
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    check("reset_pc_write", int'(pc_write), 0);
    check("reset_ex_mem_flush", int'(ex_mem_flush), 1);
    tick();
    check("reset_state", int'(state), 0);
    check("reset_stall_cycles", int'(stall_cycles), 0);

    // Load x5 in EX, ID reads rs2=x5.
    drive(0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 1);
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_id_ex_bubble", int'(id_ex_bubble), 1);
    tick();
    check("lu_stall_cycles", int'(stall_cycles), 1);
    idle();
    check("lu_release_pc_write", int'(pc_write), 1);
    tick();

    // rd=x0 never stalls; rs1 match without rs1_used does not stall; with it, it does.
    drive(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1);
    check("x0_no_stall", int'(pc_write), 1);
    tick();
    drive(0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 1);
    check("rs1_unused_no_stall", int'(pc_write), 1);
    tick();
    drive(0, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 1);
    check("rs1_used_stall", int'(if_id_write), 0);
    tick();

    // Memory wait: four not-ready cycles frozen, release on the fifth; branch ignored mid-wait.
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    check("mw_entry_bubble", int'(mem_wb_bubble), 1);
    tick();
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
    check("mw_branch_ignored", int'(id_ex_flush), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      tick();
    end
    check("mw_state", int'(state), 1);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    check("mw_release_mem_wb_write", int'(mem_wb_write), 1);
    tick();
    check("mw_back_to_run", int'(state), 0);
    check("mw_stall_cycles", int'(stall_cycles), 6);

    // Memory never ready: forced release on the 15th cycle, sticky error.
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    check("to_release_pc_write", int'(pc_write), 1);
    check("to_err_not_yet", int'(timeout_err), 0);
    tick();
    check("to_err_set", int'(timeout_err), 1);
    check("to_stall_cycles", int'(stall_cycles), 20);
    idle();
    tick();
    check("to_err_sticky", int'(timeout_err), 1);

    // Taken branch: three flushes on cycle 0, if_id_flush for three cycles.
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    check("br_ex_mem_flush", int'(ex_mem_flush), 1);
    tick();
    check("br_state_flush", int'(state), 2);
    check("br_flush_count", int'(flush_count), 1);
    idle();
    check("br_c1_if_id_flush", int'(if_id_flush), 1);
    check("br_c1_id_ex_flush", int'(id_ex_flush), 0);
    tick();
    idle();
    check("br_c2_if_id_flush", int'(if_id_flush), 1);
    tick();
    idle();
    check("br_done_if_id_flush", int'(if_id_flush), 0);
    tick();

    // Branch and load-use together: flush wins; reload in FLUSH; reset aborts FLUSH.
    drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 1);
    check("brlu_pc_write", int'(pc_write), 1);
    check("brlu_no_bubble", int'(id_ex_bubble), 0);
    tick();
    drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 1, 0);
    tick();
    check("reload_flush_count", int'(flush_count), 3);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    tick();
    check("rst_in_flush_state", int'(state), 0);
    check("rst_clears_timeout", int'(timeout_err), 0);
    check("rst_clears_flush_count", int'(flush_count), 0);

    // Reset mid memory wait.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    tick();
    check("rst_in_wait_state", int'(state), 0);
    idle();
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
